// File: rtl/panel_pkg.sv
// Shared definitions for the front-panel input controller: run-control FSM
// encoding, switch bit positions and cpu_tick speed codes.
package panel_pkg;

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_HALT  = 2'd1,
        S_RUN   = 2'd2,
        S_STEP  = 2'd3
    } panel_state_t;

    // Switch bit positions
    localparam int SW_RST_REQ = 15;
    localparam int SW_RUN     = 14;
    localparam int SW_SPD_HI  = 13;
    localparam int SW_SPD_LO  = 12;
    localparam int SW_STEP    = 11;
    localparam int SW_OP_HI   = 10;
    localparam int SW_OP_LO   = 8;
    localparam int SW_ADDR_HI = 7;
    localparam int SW_ADDR_LO = 0;

    // cpu_tick speed codes
    localparam logic [1:0] SPD_FAST = 2'b00;
    localparam logic [1:0] SPD_MID  = 2'b01;
    localparam logic [1:0] SPD_SLOW = 2'b10;
    localparam logic [1:0] SPD_MAX  = 2'b11;

    // Counter width able to hold 0..n-1 (at least one bit).
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/panel_tick_div.sv
// cpu_tick rate divider. Counts 0..N-1 while enabled, N selected by speed;
// tick is high in the cycle the count reaches N-1 (every cycle for SPD_MAX).
// Disable or a speed change restarts the count so the first tick comes N
// cycles after (re)start.
module panel_tick_div
    import panel_pkg::*;
#(
    parameter int DIV_SLOW = 50000000,
    parameter int DIV_MID  = 1000000,
    parameter int DIV_FAST = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] speed,
    output logic       tick
);

    localparam int DIV_MAX_A = (DIV_SLOW > DIV_MID) ? DIV_SLOW : DIV_MID;
    localparam int DIV_MAX   = (DIV_MAX_A > DIV_FAST) ? DIV_MAX_A : DIV_FAST;
    localparam int DIV_W     = cnt_width(DIV_MAX);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] term;
    logic [1:0]       speed_q;
    logic             speed_chg;

    // Terminal count for the selected speed
    always_comb begin
        term = '0;
        case (speed)
            SPD_FAST: term = DIV_W'(DIV_FAST - 1);
            SPD_MID:  term = DIV_W'(DIV_MID - 1);
            SPD_SLOW: term = DIV_W'(DIV_SLOW - 1);
            default:  term = '0;
        endcase
    end

    assign speed_chg = (speed != speed_q);
    assign tick      = en && ((speed == SPD_MAX) || (!speed_chg && (cnt == term)));

    // Period counter; cleared when idle, on terminal count or on speed change
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            speed_q <= SPD_FAST;
        end else begin
            speed_q <= speed;
            if (!en || speed_chg || (cnt == term)) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/panel_input_ctrl.sv
// Front-panel input controller: synchronises and debounces sw[15:0] and
// derives CPU run control (cpu_tick, go, cpu_rst) and LED view selection
// (display_op, ram_display_addr).
// Optional feature macro: AUTO_SCAN_EN -- with sw address field 8'hFF the
// displayed RAM address steps through 0..1023 every SCAN_PERIOD cycles.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_RESET | cpu_rst high; leaves after RST_HOLD cycles without reset request
// S_HALT  | CPU stopped, waiting for run or a single-step request
// S_RUN   | go high, cpu_tick at the divider rate
// S_STEP  | one cycle with go and cpu_tick high, then back to S_HALT
module panel_input_ctrl
    import panel_pkg::*;
#(
    parameter int DB_PERIOD   = 100000,
    parameter int DIV_SLOW    = 50000000,
    parameter int DIV_MID     = 1000000,
    parameter int DIV_FAST    = 1000,
    parameter int RST_HOLD    = 16
`ifdef AUTO_SCAN_EN
    ,
    parameter int SCAN_PERIOD = 50000000
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] sw,
    output logic        cpu_tick,
    output logic        go,
    output logic        cpu_rst,
    output logic [2:0]  display_op,
    output logic [9:0]  ram_display_addr
);

    localparam int DB_W   = cnt_width(DB_PERIOD);
    localparam int HOLD_W = cnt_width(RST_HOLD);

    logic [15:0]       sw_meta;
    logic [15:0]       sw_sync;
    logic [15:0]       sw_samp;
    logic [15:0]       sw_db;
    logic [15:0]       sw_agree;
    logic [DB_W-1:0]   db_cnt;
    logic              step_prev;
    logic              step_req;
    panel_state_t      state;
    logic [HOLD_W-1:0] hold_cnt;
    logic              div_tick;
    logic              run_en;

    // Two-flop synchroniser for the asynchronous switch inputs
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= sw;
            sw_sync <= sw_meta;
        end
    end

    assign sw_agree = ~(sw_sync ^ sw_samp);

    // Shared sample tick; a bit is accepted when two consecutive samples agree
    always_ff @(posedge clk) begin
        if (rst) begin
            db_cnt  <= '0;
            sw_samp <= '0;
            sw_db   <= '0;
        end else if (db_cnt == DB_W'(DB_PERIOD - 1)) begin
            db_cnt  <= '0;
            sw_samp <= sw_sync;
            sw_db   <= (sw_sync & sw_agree) | (sw_db & ~sw_agree);
        end else begin
            db_cnt  <= db_cnt + 1'b1;
        end
    end

    // Rising-edge detect on the debounced step switch
    always_ff @(posedge clk) begin
        if (rst) begin
            step_prev <= 1'b0;
        end else begin
            step_prev <= sw_db[SW_STEP];
        end
    end

    assign step_req = sw_db[SW_STEP] & ~step_prev;
    assign run_en   = (state == S_RUN);

    panel_tick_div #(
        .DIV_SLOW (DIV_SLOW),
        .DIV_MID  (DIV_MID),
        .DIV_FAST (DIV_FAST)
    ) u_tick_div (
        .clk   (clk),
        .rst   (rst),
        .en    (run_en),
        .speed (sw_db[SW_SPD_HI:SW_SPD_LO]),
        .tick  (div_tick)
    );

    // Run-control FSM with registered go / cpu_rst / cpu_tick
    always_ff @(posedge clk) begin
        if (rst || sw_db[SW_RST_REQ]) begin
            state    <= S_RESET;
            hold_cnt <= '0;
            go       <= 1'b0;
            cpu_rst  <= 1'b1;
            cpu_tick <= 1'b0;
        end else begin
            case (state)
                S_RESET: begin
                    go       <= 1'b0;
                    cpu_tick <= 1'b0;
                    if (hold_cnt == HOLD_W'(RST_HOLD - 1)) begin
                        state    <= S_HALT;
                        hold_cnt <= '0;
                        cpu_rst  <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                        cpu_rst  <= 1'b1;
                    end
                end
                S_HALT: begin
                    cpu_rst <= 1'b0;
                    if (sw_db[SW_RUN]) begin
                        state    <= S_RUN;
                        go       <= 1'b1;
                        cpu_tick <= 1'b0;
                    end else if (step_req) begin
                        state    <= S_STEP;
                        go       <= 1'b1;
                        cpu_tick <= 1'b1;
                    end else begin
                        go       <= 1'b0;
                        cpu_tick <= 1'b0;
                    end
                end
                S_RUN: begin
                    cpu_rst <= 1'b0;
                    if (!sw_db[SW_RUN]) begin
                        state    <= S_HALT;
                        go       <= 1'b0;
                        cpu_tick <= 1'b0;
                    end else begin
                        go       <= 1'b1;
                        cpu_tick <= div_tick;
                    end
                end
                S_STEP: begin
                    state    <= S_HALT;
                    go       <= 1'b0;
                    cpu_rst  <= 1'b0;
                    cpu_tick <= 1'b0;
                end
                default: begin
                    state    <= S_RESET;
                    hold_cnt <= '0;
                    go       <= 1'b0;
                    cpu_rst  <= 1'b1;
                    cpu_tick <= 1'b0;
                end
            endcase
        end
    end

    // LED view select
    always_ff @(posedge clk) begin
        if (rst) begin
            display_op <= '0;
        end else begin
            display_op <= sw_db[SW_OP_HI:SW_OP_LO];
        end
    end

`ifdef AUTO_SCAN_EN
    localparam int SCAN_W = cnt_width(SCAN_PERIOD);

    logic [SCAN_W-1:0] scan_cnt;
    logic              scan_active;

    // Displayed address: auto-scan when the address field is all ones
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_display_addr <= '0;
            scan_cnt         <= '0;
            scan_active      <= 1'b0;
        end else if (sw_db[SW_ADDR_HI:SW_ADDR_LO] == 8'hFF) begin
            scan_active <= 1'b1;
            if (!scan_active) begin
                ram_display_addr <= '0;
                scan_cnt         <= '0;
            end else if (scan_cnt == SCAN_W'(SCAN_PERIOD - 1)) begin
                ram_display_addr <= ram_display_addr + 1'b1;
                scan_cnt         <= '0;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
        end else begin
            scan_active      <= 1'b0;
            scan_cnt         <= '0;
            ram_display_addr <= {2'b00, sw_db[SW_ADDR_HI:SW_ADDR_LO]};
        end
    end
`else
    // Displayed address follows the debounced address switches
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_display_addr <= '0;
        end else begin
            ram_display_addr <= {2'b00, sw_db[SW_ADDR_HI:SW_ADDR_LO]};
        end
    end
`endif

endmodule

// File: tb/tb_panel_input_ctrl.sv
// Directed bench for panel_input_ctrl with small timing parameters.
module tb_panel_input_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] sw  = 16'h0000;
    logic        cpu_tick;
    logic        go;
    logic        cpu_rst;
    logic [2:0]  display_op;
    logic [9:0]  ram_display_addr;

    int total = 0;
    int bad   = 0;

    panel_input_ctrl #(
        .DB_PERIOD   (4),
        .DIV_SLOW    (7),
        .DIV_MID     (5),
        .DIV_FAST    (3),
        .RST_HOLD    (4)
`ifdef AUTO_SCAN_EN
        ,
        .SCAN_PERIOD (8)
`endif
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .sw               (sw),
        .cpu_tick         (cpu_tick),
        .go               (go),
        .cpu_rst          (cpu_rst),
        .display_op       (display_op),
        .ram_display_addr (ram_display_addr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic cycles(input int n);
        repeat (n) cyc();
    endtask

    // Count ticks, go-high cycles and coinciding ones over n cycles
    task automatic monitor(input int n, output int nt, output int ng, output int nb);
        nt = 0; ng = 0; nb = 0;
        for (int k = 0; k < n; k++) begin
            cyc();
            if (cpu_tick) nt++;
            if (go) ng++;
            if (cpu_tick && go) nb++;
        end
    endtask

    // Wait for a tick, then return the cycle distance to the next one (-1 on timeout)
    task automatic tick_gap(output int gap);
        gap = -1;
        for (int k = 0; k < 40 && !cpu_tick; k++) cyc();
        if (!cpu_tick) return;
        for (int k = 1; k <= 40; k++) begin
            cyc();
            if (cpu_tick) begin
                gap = k;
                return;
            end
        end
    endtask

    initial begin
        int nt, ng, nb, gap, n;
        logic [11:0] mask;

        // Reset and cpu_rst hold
        rst = 1'b1;
        sw  = 16'h0000;
        cyc();
        chk("rst_cpu_rst", cpu_rst, 1);
        chk("rst_go", go, 0);
        chk("rst_tick", cpu_tick, 0);
        chk("rst_op", display_op, 0);
        chk("rst_addr", ram_display_addr, 0);
        rst = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cyc();
            chk($sformatf("hold_%0d", k), cpu_rst, (k < 4) ? 1 : 0);
            chk($sformatf("hold_go_%0d", k), go, 0);
        end

        // Display selection
        sw = 16'h053C;
        cycles(16);
        chk("disp_op", display_op, 3'd5);
        chk("disp_addr", ram_display_addr, 10'h03C);
        chk("disp_go", go, 0);

        // Glitch on run for one sample period
        sw = 16'h453C;
        cycles(4);
        sw = 16'h053C;
        monitor(20, nt, ng, nb);
        chk("glitch_go", ng, 0);
        chk("glitch_db", dut.sw_db, 16'h053C);

        // Run at speed 00: ticks at 3, 6, 9, 12 cycles after go rises
        sw = 16'h453C;
        for (int k = 0; k < 40; k++) begin
            cyc();
            if (go) break;
        end
        chk("run_go", go, 1);
        chk("run_first_tick", cpu_tick, 0);
        mask = '0;
        for (int k = 0; k < 12; k++) begin
            cyc();
            mask[k] = cpu_tick;
        end
        chk("run_fast_mask", mask, 12'h924);

        // Speed 11: tick every cycle
        sw = 16'h753C;
        cycles(16);
        monitor(10, nt, ng, nb);
        chk("run_max_ticks", nt, 10);
        chk("run_max_go", ng, 10);

        // Speed 01 and 10
        sw = 16'h553C;
        cycles(16);
        tick_gap(gap);
        chk("gap_mid", gap, 5);
        sw = 16'h653C;
        cycles(16);
        tick_gap(gap);
        chk("gap_slow", gap, 7);
        sw = 16'h453C;
        cycles(16);
        tick_gap(gap);
        chk("gap_fast", gap, 3);

        // Reset request while running at full speed
        sw = 16'hF53C;
        for (int k = 0; k < 40; k++) begin
            cyc();
            if (cpu_rst) break;
        end
        chk("rreq_cpu_rst", cpu_rst, 1);
        chk("rreq_go", go, 0);
        chk("rreq_tick", cpu_tick, 0);
        monitor(6, nt, ng, nb);
        chk("rreq_no_ticks", nt, 0);
        chk("rreq_no_go", ng, 0);
        sw = 16'h753C;
        for (int k = 0; k < 40; k++) begin
            cyc();
            if (!dut.sw_db[15]) break;
        end
        n = -1;
        for (int k = 1; k <= 10; k++) begin
            cyc();
            if (!cpu_rst) begin
                n = k;
                break;
            end
        end
        chk("rreq_release_hold", n, 4);
        cyc();
        chk("rreq_rerun_go", go, 1);

        // Single step from halt
        sw = 16'h053C;
        cycles(16);
        chk("halt_go", go, 0);
        sw = 16'h0D3C;
        monitor(20, nt, ng, nb);
        chk("step_ticks", nt, 1);
        chk("step_go", ng, 1);
        chk("step_coincide", nb, 1);
        monitor(20, nt, ng, nb);
        chk("step_held_ticks", nt, 0);
        sw = 16'h053C;
        monitor(20, nt, ng, nb);
        chk("step_release_ticks", nt, 0);

        // Run and step together: run wins
        sw = 16'h4D3C;
        for (int k = 0; k < 40; k++) begin
            cyc();
            if (go) break;
        end
        chk("rs_go", go, 1);
        chk("rs_no_step_tick", cpu_tick, 0);
        monitor(10, nt, ng, nb);
        chk("rs_go_held", ng, 10);

        // Synchronous reset in the middle of full-speed running
        sw = 16'h753C;
        cycles(16);
        chk("mid_pre_tick", cpu_tick, 1);
        rst = 1'b1;
        cyc();
        chk("mid_tick", cpu_tick, 0);
        chk("mid_go", go, 0);
        chk("mid_cpu_rst", cpu_rst, 1);
        chk("mid_op", display_op, 0);
        chk("mid_addr", ram_display_addr, 0);
        rst = 1'b0;
        cycles(16);

        // Address field all ones
        sw = 16'h00FF;
        for (int k = 0; k < 40; k++) begin
            cyc();
            if (dut.sw_db[7:0] == 8'hFF) break;
        end
`ifdef AUTO_SCAN_EN
        cyc();
        chk("scan_start", ram_display_addr, 10'd0);
        cycles(7);
        chk("scan_hold0", ram_display_addr, 10'd0);
        cyc();
        chk("scan_step1", ram_display_addr, 10'd1);
        cycles(8);
        chk("scan_step2", ram_display_addr, 10'd2);
        for (int k = 0; k < 9000; k++) begin
            cyc();
            if (ram_display_addr == 10'd1023) break;
        end
        chk("scan_reach_max", ram_display_addr, 10'd1023);
        cycles(7);
        chk("scan_hold_max", ram_display_addr, 10'd1023);
        cyc();
        chk("scan_wrap", ram_display_addr, 10'd0);
`else
        cycles(2);
        chk("addr_ff", ram_display_addr, 10'h0FF);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
